// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider. Each channel produces a registered
// 50% clock with half-period H. Rate changes are deferred to a falling edge, so no phase is ever cut short.
module clk_div_multi #(
    parameter  int NUM_CH     = 4,
    parameter  int DIV_W      = 8,
    parameter  int RESET_HALF = 1,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_half,
    input  logic              cfg_sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick_rise,
    output logic [NUM_CH-1:0] pend,
    output logic              cfg_err
);

    logic [31:0] cfg_ch_ext;
    logic        cfg_err_d;
    logic        cfg_err_q;

    assign cfg_ch_ext = 32'(cfg_ch);

    always_comb begin
        cfg_err_d = cfg_valid && (cfg_ch_ext >= 32'(NUM_CH));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] act_h_q, act_h_d;
            logic [DIV_W-1:0] pnd_h_q, pnd_h_d;
            logic [DIV_W-1:0] cnt_q, cnt_d;
            logic             clk_q, clk_d;
            logic             tick_q, tick_d;
            logic             pend_q, pend_d;
            logic             wr;
            logic             at_end;

            assign wr     = cfg_valid && (cfg_ch_ext == 32'(gi));
            assign at_end = (cnt_q == act_h_q - DIV_W'(1));

            always_comb begin
                act_h_d = act_h_q;
                pnd_h_d = pnd_h_q;
                cnt_d   = cnt_q;
                clk_d   = clk_q;
                pend_d  = pend_q;
                tick_d  = 1'b0;
                if (cfg_sync) begin
                    cnt_d  = '0;
                    clk_d  = 1'b0;
                    pend_d = 1'b0;
                    if (wr) begin
                        act_h_d = cfg_half;
                    end else if (pend_q) begin
                        act_h_d = pnd_h_q;
                    end
                end else if (act_h_q == '0) begin
                    // Stopped: a new value takes over at once, output stays low
                    cnt_d = '0;
                    clk_d = 1'b0;
                    if (wr) begin
                        act_h_d = cfg_half;
                    end
                end else begin
                    if (at_end) begin
                        cnt_d = '0;
                        clk_d = ~clk_q;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                    if (at_end && clk_q) begin
                        // Falling edge: the only safe point to change rate
                        if (wr) begin
                            act_h_d = cfg_half;
                            pend_d  = 1'b0;
                        end else if (pend_q) begin
                            act_h_d = pnd_h_q;
                            pend_d  = 1'b0;
                        end
                    end else if (wr) begin
                        pnd_h_d = cfg_half;
                        pend_d  = 1'b1;
                    end
                    tick_d = clk_d & ~clk_q;
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    act_h_q <= DIV_W'(RESET_HALF);
                    pnd_h_q <= '0;
                    cnt_q   <= '0;
                    clk_q   <= 1'b0;
                    tick_q  <= 1'b0;
                    pend_q  <= 1'b0;
                end else begin
                    act_h_q <= act_h_d;
                    pnd_h_q <= pnd_h_d;
                    cnt_q   <= cnt_d;
                    clk_q   <= clk_d;
                    tick_q  <= tick_d;
                    pend_q  <= pend_d;
                end
            end

            assign clk_out[gi]   = clk_q;
            assign tick_rise[gi] = tick_q;
            assign pend[gi]      = pend_q;
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: a vector table for steady-state, rate change,
// stop/restart and sync behaviour, plus hand sequences for cfg_err and mid-pending reset.
module tb_clk_div_multi;

    logic       clock = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_half;
    logic       cfg_sync;
    logic [3:0] clk_out;
    logic [3:0] tick_rise;
    logic [3:0] pend;
    logic       cfg_err;

    logic       cfg_valid5;
    logic [2:0] cfg_ch5;
    logic [4:0] clk_out5;
    logic [4:0] tick_rise5;
    logic [4:0] pend5;
    logic       cfg_err5;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clock = ~clock;

    clk_div_multi #(.NUM_CH(4), .DIV_W(8), .RESET_HALF(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .cfg_sync  (cfg_sync),
        .clk_out   (clk_out),
        .tick_rise (tick_rise),
        .pend      (pend),
        .cfg_err   (cfg_err)
    );

    // Five channels so that an out-of-range index (5) is expressible on cfg_ch
    clk_div_multi #(.NUM_CH(5), .DIV_W(8), .RESET_HALF(1)) dut5 (
        .clock     (clock),
        .reset     (reset),
        .cfg_valid (cfg_valid5),
        .cfg_ch    (cfg_ch5),
        .cfg_half  (cfg_half),
        .cfg_sync  (1'b0),
        .clk_out   (clk_out5),
        .tick_rise (tick_rise5),
        .pend      (pend5),
        .cfg_err   (cfg_err5)
    );

    typedef struct {
        logic       v;
        logic [1:0] ch;
        logic [7:0] h;
        logic       s;
        logic [3:0] clk;
        logic [3:0] tick;
        logic [3:0] pend;
    } vec_t;

    localparam int NVEC = 52;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic v, input logic [1:0] ch, input logic [7:0] h,
                                input logic s, input logic [3:0] c, input logic [3:0] t,
                                input logic [3:0] p);
        vec_t r;
        r.v = v; r.ch = ch; r.h = h; r.s = s; r.clk = c; r.tick = t; r.pend = p;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0; cfg_sync = 1'b0;
        cfg_valid5 = 1'b0; cfg_ch5 = '0;

        // Edges 1..16: all channels at H=1 toggle every cycle
        for (int k = 1; k <= 16; k++) begin
            tbl[k-1] = mk(0, 0, 0, 0, (k % 2) ? 4'hF : 4'h0, (k % 2) ? 4'hF : 4'h0, 4'h0);
        end
        // Edge 17..27: ch2 -> H=3, pending until the next fall
        tbl[16] = mk(1, 2, 3, 0, 4'hF, 4'hF, 4'h4);
        tbl[17] = mk(0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
        tbl[18] = mk(0, 0, 0, 0, 4'hB, 4'hB, 4'h0);
        tbl[19] = mk(0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
        tbl[20] = mk(0, 0, 0, 0, 4'hF, 4'hF, 4'h0);
        tbl[21] = mk(0, 0, 0, 0, 4'h4, 4'h0, 4'h0);
        tbl[22] = mk(0, 0, 0, 0, 4'hF, 4'hB, 4'h0);
        tbl[23] = mk(0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
        tbl[24] = mk(0, 0, 0, 0, 4'hB, 4'hB, 4'h0);
        tbl[25] = mk(0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
        tbl[26] = mk(0, 0, 0, 0, 4'hF, 4'hF, 4'h0);
        // Edge 28..36: ch1 stopped with H=0, restarted with H=5 (rise at 36)
        tbl[27] = mk(0, 0, 0, 0, 4'h4, 4'h0, 4'h0);
        tbl[28] = mk(1, 1, 0, 0, 4'hF, 4'hB, 4'h2);
        tbl[29] = mk(0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
        tbl[30] = mk(1, 1, 5, 0, 4'h9, 4'h9, 4'h0);
        tbl[31] = mk(0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
        tbl[32] = mk(0, 0, 0, 0, 4'hD, 4'hD, 4'h0);
        tbl[33] = mk(0, 0, 0, 0, 4'h4, 4'h0, 4'h0);
        tbl[34] = mk(0, 0, 0, 0, 4'hD, 4'h9, 4'h0);
        tbl[35] = mk(0, 0, 0, 0, 4'h2, 4'h2, 4'h0);
        // Edge 37..40: load 2,3,4 then sync together with ch3=5
        tbl[36] = mk(1, 0, 2, 0, 4'hB, 4'h9, 4'h1);
        tbl[37] = mk(1, 1, 3, 0, 4'h2, 4'h0, 4'h2);
        tbl[38] = mk(1, 2, 4, 0, 4'hE, 4'hC, 4'h6);
        tbl[39] = mk(1, 3, 5, 1, 4'h0, 4'h0, 4'h0);
        tbl[40] = mk(0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
        tbl[41] = mk(0, 0, 0, 0, 4'h1, 4'h1, 4'h0);
        tbl[42] = mk(0, 0, 0, 0, 4'h3, 4'h2, 4'h0);
        tbl[43] = mk(0, 0, 0, 0, 4'h6, 4'h4, 4'h0);
        tbl[44] = mk(0, 0, 0, 0, 4'hE, 4'h8, 4'h0);
        tbl[45] = mk(0, 0, 0, 0, 4'hD, 4'h1, 4'h0);
        // Edge 47..52: ch3 write mid-high (pending), ch0 write on its fall (direct)
        tbl[46] = mk(1, 3, 2, 0, 4'hD, 4'h0, 4'h8);
        tbl[47] = mk(1, 0, 1, 0, 4'h8, 4'h0, 4'h8);
        tbl[48] = mk(0, 0, 0, 0, 4'hB, 4'h3, 4'h8);
        tbl[49] = mk(0, 0, 0, 0, 4'h2, 4'h0, 4'h0);
        tbl[50] = mk(0, 0, 0, 0, 4'h3, 4'h1, 4'h0);
        tbl[51] = mk(0, 0, 0, 0, 4'hC, 4'hC, 4'h0);

        #1 reset = 1'b1;
        #2;
        chk("rst_clk",   32'(clk_out),   32'h0);
        chk("rst_tick",  32'(tick_rise), 32'h0);
        chk("rst_pend",  32'(pend),      32'h0);
        chk("rst_err",   32'(cfg_err),   32'h0);
        chk("rst_clk5",  32'(clk_out5),  32'h0);
        chk("rst_err5",  32'(cfg_err5),  32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        cyc = 0;

        for (int i = 0; i < NVEC; i++) begin
            cfg_valid = tbl[i].v;
            cfg_ch    = tbl[i].ch;
            cfg_half  = tbl[i].h;
            cfg_sync  = tbl[i].s;
            step();
            $display("edge %0d v=%0b ch=%0d h=%0d s=%0b clk=%h tick=%h pend=%h err=%0b",
                     cyc, tbl[i].v, tbl[i].ch, tbl[i].h, tbl[i].s, clk_out, tick_rise, pend, cfg_err);
            chk("tbl_clk",  32'(clk_out),   32'(tbl[i].clk));
            chk("tbl_tick", 32'(tick_rise), 32'(tbl[i].tick));
            chk("tbl_pend", 32'(pend),      32'(tbl[i].pend));
            chk("tbl_err",  32'(cfg_err),   32'h0);
        end
        cfg_valid = 1'b0; cfg_sync = 1'b0; cfg_ch = '0; cfg_half = '0;

        // Out-of-range write on the 5-channel instance
        cfg_valid5 = 1'b1; cfg_ch5 = 3'd5; cfg_half = 8'd3;
        step();
        cfg_valid5 = 1'b0; cfg_half = '0;
        $display("edge %0d err5 write ch=5 err5=%0b clk5=%h pend5=%h", cyc, cfg_err5, clk_out5, pend5);
        chk("err5_pulse", 32'(cfg_err5), 32'h1);
        chk("err5_pend",  32'(pend5),    32'h0);
        chk("err5_clk",   32'(clk_out5), (cyc % 2) ? 32'h1F : 32'h0);
        step();
        $display("edge %0d err5 idle err5=%0b clk5=%h", cyc, cfg_err5, clk_out5);
        chk("err5_clear", 32'(cfg_err5), 32'h0);
        chk("err5_clk2",  32'(clk_out5), (cyc % 2) ? 32'h1F : 32'h0);

        // Reset while ch3 holds a pending value
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_half = 8'd4;
        step();
        cfg_valid = 1'b0; cfg_half = '0;
        $display("edge %0d ch3 write pend=%h clk=%h", cyc, pend, clk_out);
        chk("pre_rst_pend", 32'(pend), 32'h8);
        #2 reset = 1'b1;
        #1;
        $display("async reset clk=%h pend=%h tick=%h", clk_out, pend, tick_rise);
        chk("mid_rst_clk",  32'(clk_out),   32'h0);
        chk("mid_rst_pend", 32'(pend),      32'h0);
        chk("mid_rst_tick", 32'(tick_rise), 32'h0);
        step();
        chk("hold_rst_clk", 32'(clk_out), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        cyc = 0;
        step();
        $display("edge %0d after reset clk=%h tick=%h pend=%h", cyc, clk_out, tick_rise, pend);
        chk("post_rst_clk1",  32'(clk_out),   32'hF);
        chk("post_rst_tick1", 32'(tick_rise), 32'hF);
        chk("post_rst_pend",  32'(pend),      32'h0);
        step();
        $display("edge %0d after reset clk=%h tick=%h", cyc, clk_out, tick_rise);
        chk("post_rst_clk2",  32'(clk_out),   32'h0);
        chk("post_rst_tick2", 32'(tick_rise), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
